// File: rtl/midi_pkg.sv
// Shared MIDI serial framing constants, status-byte ranges and transmitter state type.
package midi_pkg;

    localparam int         FRAME_BITS    = 10;
    localparam logic [3:0] START_BIT     = 4'd0;
    localparam logic [3:0] STOP_BIT      = 4'd9;

    localparam logic [7:0] STATUS_CH_MIN = 8'h80;
    localparam logic [7:0] STATUS_CH_MAX = 8'hEF;
    localparam logic [7:0] SYSCOM_MIN    = 8'hF0;
    localparam logic [7:0] REALTIME_MIN  = 8'hF8;

    typedef enum logic {IDLE, SEND} state_t;

    // Line level for frame position idx: start=0, data LSB-first, stop=1.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic [FRAME_BITS-1:0] frame;
        frame = {1'b1, data, 1'b0};
        return (idx > STOP_BIT) ? 1'b1 : frame[idx];
    endfunction

endpackage

// File: rtl/midi_bit_timer.sv
// Bit/byte position counter for a MIDI frame stream; TICK marks the last clock of each bit.
module midi_bit_timer
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 128
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       EN,
    input  logic       CLR,
    input  logic [1:0] BYTE_INIT,
    output logic       TICK,
    output logic [3:0] BIT,
    output logic [1:0] BYTE
);

    localparam int             CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign TICK = EN && (cnt == CNT_MAX);

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            cnt  <= '0;
            BIT  <= START_BIT;
            BYTE <= '0;
        end else if (CLR) begin
            cnt  <= '0;
            BIT  <= START_BIT;
            BYTE <= BYTE_INIT;
        end else if (EN) begin
            if (TICK) begin
                cnt <= '0;
                if (BIT == STOP_BIT) begin
                    BIT  <= START_BIT;
                    BYTE <= BYTE + 2'd1;
                end else begin
                    BIT <= BIT + 4'd1;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/midi_transmitter.sv
// MIDI OUT serializer: 1-3 byte messages as back-to-back 8N1 frames, optional running status.
module midi_transmitter
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 128,
    parameter int RUNNING_STATUS = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MSG_VALID,
    output logic       MSG_READY,
    input  logic [7:0] STATUS,
    input  logic [7:0] DATA1,
    input  logic [7:0] DATA2,
    input  logic [1:0] MSG_LEN,
    output logic       TX,
    output logic       BUSY,
    output logic       DONE,
    output logic [3:0] BIT,
    output logic [1:0] BYTE
);

    state_t     state, state_nxt;
    logic [7:0] status_q, data1_q, data2_q, last_status, tx_byte;
    logic [1:0] len_eff, last_idx, last_idx_q, start_idx, byte_init, nxt_byte;
    logic [3:0] nxt_bit;
    logic       accept, is_channel, skip, empty, launch, tick, finish, tx_nxt;

    assign accept     = MSG_VALID && MSG_READY;
    assign len_eff    = (MSG_LEN == 2'd0) ? 2'd3 : MSG_LEN;
    assign last_idx   = len_eff - 2'd1;
    assign is_channel = (STATUS >= STATUS_CH_MIN) && (STATUS <= STATUS_CH_MAX);
    assign skip       = (RUNNING_STATUS != 0) && is_channel && (STATUS == last_status);
    assign start_idx  = {1'b0, skip};
    // A lone repeated status leaves nothing to send: pulse DONE without leaving IDLE.
    assign empty      = skip && (last_idx == 2'd0);
    assign launch     = accept && !empty;
    assign finish     = (state == SEND) && tick && (BIT == STOP_BIT) && (BYTE == last_idx_q);
    assign byte_init  = launch ? start_idx : 2'd0;

    midi_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (state == SEND),
        .CLR      (launch || finish),
        .BYTE_INIT(byte_init),
        .TICK     (tick),
        .BIT      (BIT),
        .BYTE     (BYTE)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = SEND;
            SEND:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        MSG_READY = (state == IDLE);
        BUSY      = (state == SEND);
    end

    // TX is registered, so it is loaded with the level of the position the timer moves to.
    always_comb begin
        nxt_bit  = (BIT == STOP_BIT) ? START_BIT : BIT + 4'd1;
        nxt_byte = (BIT == STOP_BIT) ? BYTE + 2'd1 : BYTE;
        case (nxt_byte)
            2'd0:    tx_byte = status_q;
            2'd1:    tx_byte = data1_q;
            default: tx_byte = data2_q;
        endcase
        tx_nxt = TX;
        if (state == IDLE)  tx_nxt = !launch;
        else if (finish)    tx_nxt = 1'b1;
        else if (tick)      tx_nxt = frame_bit(tx_byte, nxt_bit);
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            TX          <= 1'b1;
            DONE        <= 1'b0;
            status_q    <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            last_idx_q  <= '0;
            last_status <= '0;
        end else begin
            TX   <= tx_nxt;
            DONE <= finish || (accept && empty);
            if (accept) begin
                status_q   <= STATUS;
                data1_q    <= DATA1;
                data2_q    <= DATA2;
                last_idx_q <= last_idx;
                if (RUNNING_STATUS != 0) begin
                    if (is_channel)
                        last_status <= STATUS;
                    else if ((STATUS >= SYSCOM_MIN) && (STATUS < REALTIME_MIN))
                        last_status <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_transmitter.sv
// Scoreboard bench: a line decoder and DONE timer check against a message-level MIDI model.
module tb_midi_transmitter;

    localparam int C = 16;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       MSG_VALID = 1'b0;
    logic [7:0] STATUS = '0, DATA1 = '0, DATA2 = '0;
    logic [1:0] MSG_LEN = '0;
    logic       MSG_READY, TX, BUSY, DONE;
    logic [3:0] BIT;
    logic [1:0] BYTE;

    midi_transmitter #(
        .CLKS_PER_BIT  (C),
        .RUNNING_STATUS(1)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .MSG_VALID(MSG_VALID),
        .MSG_READY(MSG_READY),
        .STATUS   (STATUS),
        .DATA1    (DATA1),
        .DATA2    (DATA2),
        .MSG_LEN  (MSG_LEN),
        .TX       (TX),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .BIT      (BIT),
        .BYTE     (BYTE)
    );

    always #5 CLK = ~CLK;

    int edges = 0;
    always @(posedge CLK) edges = edges + 1;

    int checks = 0;
    int passes = 0;
    bit abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edges);
    endtask

    // Scoreboard: bytes expected on the line, and edge numbers at which DONE must be seen.
    logic [7:0] exp_bytes[$];
    int         exp_done[$];
    logic [7:0] ref_last = '0;

    logic       in_frame = 1'b0;
    int         ph = 0;
    int         bi;
    logic [7:0] shreg = '0;

    always @(negedge CLK) begin
        if (RESET) begin
            if (DONE) begin
                if (exp_done.size() == 0) check("done_unexpected", 32'(exp_done.size()), 1);
                else check("done_edge", 32'(edges), 32'(exp_done.pop_front()));
            end
            if (!in_frame) begin
                if (TX == 1'b0) begin
                    in_frame = 1'b1;
                    ph = 0;
                end
            end else begin
                ph++;
            end
            if (in_frame && (ph % C) == C / 2) begin
                bi = ph / C;
                if (bi >= 1 && bi <= 8) begin
                    shreg[bi-1] = TX;
                end else if (bi == 9) begin
                    check("stop_bit", 32'(TX), 1);
                    if (exp_bytes.size() == 0) check("byte_unexpected", 32'(exp_bytes.size()), 1);
                    else check("line_byte", 32'(shreg), 32'(exp_bytes.pop_front()));
                    in_frame = 1'b0;
                end
            end
        end
    end

    // Called at a negedge. Drives junk with MSG_VALID while the block is busy.
    task automatic send(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                        input logic [1:0] len);
        int         waited, n, sk, sent, acc;
        logic [7:0] m[3];
        if (abort) return;
        waited = 0;
        while (!MSG_READY && waited < 2000) begin
            check("busy_while_not_ready", 32'(BUSY), 1);
            MSG_VALID = 1'($urandom);
            STATUS    = 8'($urandom);
            DATA1     = 8'($urandom);
            DATA2     = 8'($urandom);
            MSG_LEN   = 2'($urandom);
            @(negedge CLK);
            waited++;
        end
        if (waited >= 2000) begin
            check("ready_timeout", 32'(waited), 0);
            abort = 1'b1;
            return;
        end
        n  = (len == 2'd0) ? 3 : int'(len);
        sk = (st >= 8'h80 && st <= 8'hEF && st == ref_last) ? 1 : 0;
        if (st >= 8'h80 && st <= 8'hEF) ref_last = st;
        else if (st >= 8'hF0 && st <= 8'hF7) ref_last = 8'h00;
        m[0] = st; m[1] = d1; m[2] = d2;
        for (int k = sk; k < n; k++) exp_bytes.push_back(m[k]);
        sent = n - sk;
        acc  = edges + 1;
        exp_done.push_back((sent == 0) ? acc : acc + 10 * sent * C);
        STATUS = st; DATA1 = d1; DATA2 = d2; MSG_LEN = len;
        MSG_VALID = 1'b1;
        @(posedge CLK);
        #1;
        MSG_VALID = (sent == 0) ? 1'b0 : 1'($urandom);
        STATUS = 8'($urandom);
        @(negedge CLK);
        check("tx_after_accept", 32'(TX), (sent == 0) ? 1 : 0);
        check("busy_after_accept", 32'(BUSY), (sent == 0) ? 0 : 1);
        check("ready_after_accept", 32'(MSG_READY), (sent == 0) ? 1 : 0);
        check("byte_after_accept", 32'(BYTE), (sent != 0 && sk == 1) ? 1 : 0);
    endtask

    task automatic reset_state_checks(input string tag);
        check({tag, "_tx"}, 32'(TX), 1);
        check({tag, "_busy"}, 32'(BUSY), 0);
        check({tag, "_done"}, 32'(DONE), 0);
        check({tag, "_bit"}, 32'(BIT), 0);
        check({tag, "_byte"}, 32'(BYTE), 0);
        check({tag, "_ready"}, 32'(MSG_READY), 1);
    endtask

    initial begin
        int waited, k;
        logic [7:0] st;
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        reset_state_checks("reset");
        RESET = 1'b1;

        send(8'h90, 8'h3C, 8'h64, 2'd3);
        send(8'h90, 8'h40, 8'h00, 2'd3);
        send(8'h80, 8'h40, 8'h00, 2'd3);
        send(8'hF8, 8'h11, 8'h22, 2'd1);
        send(8'h80, 8'h12, 8'h34, 2'd2);
        send(8'hF0, 8'h7E, 8'h01, 2'd1);
        send(8'h80, 8'h55, 8'h66, 2'd2);
        send(8'h80, 8'h01, 8'h02, 2'd1);
        send(8'h05, 8'hA5, 8'h5A, 2'd0);
        send(8'h80, 8'h33, 8'h44, 2'd2);

        if (!abort) begin
            send(8'h91, 8'h12, 8'h34, 2'd3);
            MSG_VALID = 1'b0;
            repeat (14 * C) @(negedge CLK);
            RESET = 1'b0;
            @(posedge CLK);
            #1;
            exp_bytes.delete();
            exp_done.delete();
            in_frame = 1'b0;
            ref_last = 8'h00;
            @(negedge CLK);
            reset_state_checks("midreset");
            RESET = 1'b1;
            send(8'h91, 8'h3C, 8'h64, 2'd3);
        end

        for (int i = 0; i < 20 && !abort; i++) begin
            k = $urandom_range(0, 3);
            case (k)
                0:       st = 8'h90;
                1:       st = 8'h80;
                2:       st = 8'hF0 | 8'($urandom_range(0, 15));
                default: st = 8'($urandom);
            endcase
            send(st, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), 2'($urandom));
        end

        MSG_VALID = 1'b0;
        waited = 0;
        while ((exp_bytes.size() != 0 || exp_done.size() != 0) && waited < 3000) begin
            @(negedge CLK);
            waited++;
        end
        check("drain_left", 32'(exp_bytes.size() + exp_done.size()), 0);
        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/midi_transmitter.md
Name: midi_transmitter

Overview:
- Serializes one MIDI message of 1-3 bytes (status, data1, data2) onto a single UART-style line TX.
- Uses the same bit timing and frame format as our MIDI receiver: CLKS_PER_BIT clocks per bit, 1 start, 8 data LSB-first, 1 stop, idle high.
- Sits between the note/control generator logic and the MIDI OUT pin.
- Optional running-status compression suppresses repeated channel status bytes.

Parameters:
- CLKS_PER_BIT, 128: clock cycles per serial bit; must be >= 2.
- RUNNING_STATUS, 0: 1 enables suppression of repeated channel status bytes.

Ports:
- CLK  input  1  system clock
- RESET  input  1  synchronous, active-low reset
- MSG_VALID  input  1  message presented on STATUS/DATA1/DATA2/MSG_LEN
- MSG_READY  output  1  block can accept a message; combinational, = (state==IDLE)
- STATUS  input  8  first byte
- DATA1  input  8  second byte
- DATA2  input  8  third byte
- MSG_LEN  input  2  bytes to send: 1, 2 or 3; 0 is treated as 3
- TX  output  1  serial line, registered, idle high
- BUSY  output  1  high from the accept edge until the final stop bit ends
- DONE  output  1  one-cycle pulse when the final stop bit completes
- BIT  output  4  bit index in the current frame, 0=start, 1-8=data, 9=stop
- BYTE  output  2  index of the byte being sent, 0-2

Behaviour:
- Reset (RESET low at a posedge):
  - TX=1, BUSY=0, DONE=0, BIT=0, BYTE=0.
  - State=IDLE; bit-timer=0; last_status=0x00 (none).
  - Takes effect at the next edge even mid-frame; the truncated frame is abandoned.
- States:
  - IDLE: TX=1.
  - SEND: transmitting.
- Accept:
  - Occurs at a posedge with MSG_VALID & MSG_READY.
  - Latch all inputs, set BUSY=1, go to SEND.
  - BYTE starts at 0, or at 1 when running status skips the status byte.
  - TX=0 (start bit) from the cycle after the accept edge.
  - MSG_VALID while BUSY is ignored; inputs are not sampled.
- Bit timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The bit-timer counts 0..CLKS_PER_BIT-1, then BIT increments.
  - At BIT=9 overflow: if more bytes remain, BYTE++ and BIT=0, with no gap between frames. Otherwise go to IDLE, BUSY=0, DONE=1 for one cycle.
- Data bits: BIT=k (k=1..8) drives byte[k-1].
- Duration: an L-byte message occupies 10*L*CLKS_PER_BIT cycles of TX.
  - MSG_READY is high the cycle after DONE.
  - Back-to-back accepts are spaced 10*L*CLKS_PER_BIT+1 edges apart; TX stays high in the gap cycle.
- MSG_LEN:
  - 1: STATUS only.
  - 2: STATUS, DATA1.
  - 3: all three.
  - A skipped status byte reduces the bytes actually sent by one.
- Running status (RUNNING_STATUS=1 only):
  - STATUS in 0x80-0xEF and equal to last_status: skip byte 0. Otherwise send it and set last_status=STATUS.
  - STATUS in 0xF0-0xF7: always sent; clears last_status to 0x00.
  - STATUS in 0xF8-0xFF (realtime): always sent; last_status unchanged.
  - STATUS < 0x80: sent verbatim; last_status unchanged.
  - last_status updates at the accept edge.
  - MSG_LEN=1 with a skipped status sends nothing: DONE pulses the cycle after accept and TX stays high.
- With RUNNING_STATUS=0, every byte is always sent and last_status is unused.
- Counter widths:
  - Bit-timer: $clog2(CLKS_PER_BIT) bits.
  - No wrap beyond BIT=9 or BYTE=2 is legal.

Decomposition:
- Package midi_pkg holds:
  - FRAME_BITS=10, START_BIT=0, STOP_BIT=9.
  - STATUS_CH_MIN=0x80, STATUS_CH_MAX=0xEF, SYSCOM_MIN=0xF0, REALTIME_MIN=0xF8.
  - State enum {IDLE, SEND}.
- One sub-module, midi_bit_timer:
  - Inputs: CLK, RESET, EN, CLR.
  - Outputs: TICK at the end of each bit period, BIT, BYTE.
  - Same counting contract as the receiver timer, so both ends share timing.
- The top level holds the handshake, byte mux, running-status logic and TX register.

Test Plan:
- Note-on 0x90,0x3C,0x64, MSG_LEN=3, CLKS_PER_BIT=128 -> TX low from cycle 1. Mid-bit samples decode 0x90, 0x3C, 0x64 with stop=1. DONE exactly 3840 cycles after accept.
- RUNNING_STATUS=1: two messages 0x90,0x3C,0x64 then 0x90,0x40,0x00 -> second message sends only 0x40,0x00 (2560 cycles). A third message with 0x80 sends its status.
- Realtime 0xF8, MSG_LEN=1, between two 0x90 messages -> 0xF8 sent, last_status kept, 0x90 still suppressed afterward. 0xF0 instead -> next 0x90 is sent.
- MSG_VALID held high while BUSY with changing data -> no effect, MSG_READY=0. Data is accepted exactly one cycle after DONE.
- RESET low mid data bit of byte 1 -> TX=1, BUSY=0, BIT=BYTE=0 at the next edge. A new message afterward is sent with its status byte.
- Loopback TX into the MIDI receiver, CLKS_PER_BIT=128, note-on 0x90,0x3C,0x64 -> the receiver's captured note byte equals 0x3C.
